// File: rtl/mod_n_pkg.sv
// Shared helpers for the mod-N counter family: digit width and top digit value.
package mod_n_pkg;

    // Bits needed to hold one digit of a mod-n counter (at least one bit).
    function automatic int digit_width(input int n);
        int w;
        w = $clog2(n);
        return (w < 1) ? 1 : w;
    endfunction

    // Largest legal digit value; a down digit wraps from 0 to this.
    function automatic int digit_max(input int n);
        return n - 1;
    endfunction

endpackage

// File: rtl/mod_n_down_digit.sv
// One mod-N down-counting digit with a combinational borrow to the next digit.
module mod_n_down_digit
    import mod_n_pkg::*;
#(
    parameter int N = 3,
    parameter int W = digit_width(N)
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         clear_i,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    input  logic         borrow_i,
    output logic [W-1:0] digit_o,
    output logic         borrow_o
);

    localparam logic [W-1:0] MAX_D = W'(digit_max(N));

    logic [W-1:0] digit_q;

    // NOTE: registered state uses non-blocking assignments so every digit
    // samples the pre-edge values of its neighbours on the same clock edge.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            digit_q <= '0;
        end else if (clear_i) begin
            digit_q <= '0;
        end else if (load_i) begin
            digit_q <= load_val_i;
        end else if (borrow_i) begin
            digit_q <= (digit_q == '0) ? MAX_D : digit_q - W'(1);
        end
    end

    assign digit_o  = digit_q;
    assign borrow_o = borrow_i && (digit_q == '0);

endmodule

// File: rtl/mod_n_down_counter_sync.sv
// Multi-digit mod-N down counter: rippled digit borrows, validated load, pulse flags.
module mod_n_down_counter_sync
    import mod_n_pkg::*;
#(
    parameter int N      = 3,
    parameter int DIGITS = 2,
    parameter int W      = digit_width(N)
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                clear_i,
    input  logic                load_i,
    input  logic [DIGITS*W-1:0] load_val_i,
    input  logic                decr_i,
    output logic [DIGITS*W-1:0] count_o,
    output logic                zero_o,
    output logic                borrow_o,
    output logic                load_err_o
);

    localparam logic [W-1:0] MAX_D = W'(digit_max(N));

    logic [DIGITS:0]   borrow_chain;
    logic [DIGITS-1:0] digit_ok;
    logic              load_ok;
    logic              borrow_q;
    logic              load_err_q;

    // A load cycle (accepted or rejected) always swallows the decrement.
    assign borrow_chain[0] = decr_i && !clear_i && !load_i;
    assign load_ok         = &digit_ok;

    for (genvar k = 0; k < DIGITS; k++) begin : g_digit
        assign digit_ok[k] = (load_val_i[k*W +: W] <= MAX_D);

        mod_n_down_digit #(
            .N (N),
            .W (W)
        ) u_digit (
            .clk_i      (clk_i),
            .rst_ni     (rst_ni),
            .clear_i    (clear_i),
            .load_i     (load_i && load_ok),
            .load_val_i (load_val_i[k*W +: W]),
            .borrow_i   (borrow_chain[k]),
            .digit_o    (count_o[k*W +: W]),
            .borrow_o   (borrow_chain[k+1])
        );
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            borrow_q   <= 1'b0;
            load_err_q <= 1'b0;
        end else begin
            borrow_q   <= borrow_chain[DIGITS];
            load_err_q <= !clear_i && load_i && !load_ok;
        end
    end

    assign zero_o     = (count_o == '0);
    assign borrow_o   = borrow_q;
    assign load_err_o = load_err_q;

endmodule
